// File: rtl/systolic_array_is_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_is_ctrl_if
// Purpose  : Job/request and array/buffer control bundle for the
//            input-stationary systolic array job sequencer.
//            master : job scheduler / host side (drives the job request,
//                     observes all control outputs)
//            slave  : the sequencer itself
// Signals  : start, num_vectors, in_base, w_base, [reuse_inputs],
//            busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
//            input_en, process_en, psum_valid, psum_idx
// Options  : SA_CTRL_INPUT_REUSE_EN adds the reuse_inputs request bit.
// Revision : 1.0  initial release
// ============================================================================
interface systolic_array_is_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 9
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  num_vectors;
    logic [ADDR_WIDTH-1:0] in_base;
    logic [ADDR_WIDTH-1:0] w_base;
`ifdef SA_CTRL_INPUT_REUSE_EN
    logic                  reuse_inputs;
`endif
    logic                  busy;
    logic                  done;
    logic                  in_rd_en;
    logic [ADDR_WIDTH-1:0] in_rd_addr;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  input_en;
    logic                  process_en;
    logic                  psum_valid;
    logic [CNT_WIDTH-1:0]  psum_idx;

    modport master (
`ifdef SA_CTRL_INPUT_REUSE_EN
        output reuse_inputs,
`endif
        output start, num_vectors, in_base, w_base,
        input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
        input  input_en, process_en, psum_valid, psum_idx
    );

    modport slave (
`ifdef SA_CTRL_INPUT_REUSE_EN
        input  reuse_inputs,
`endif
        input  start, num_vectors, in_base, w_base,
        output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
        output input_en, process_en, psum_valid, psum_idx
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array_is_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_is_ctrl
// Purpose  : Job sequencer for the input-stationary systolic array. On start
//            it loads ARRAY_HEIGHT input rows (input_en), streams num_vectors
//            weight vectors (process_en), tags each emerging psum vector with
//            psum_valid/psum_idx and pulses done at the end of the job.
//            Only addresses and enables are produced; no data passes through.
// Ports    : clk   - clock
//            rst_n - synchronous active-low reset
//            ctrl  - systolic_array_is_ctrl_if.slave (job request in,
//                    buffer read enables/addresses, array enables, psum tags)
// Options  : SA_CTRL_INPUT_REUSE_EN - when defined, reuse_inputs=1 at start
//            skips LOAD so the previous job's stationary inputs are reused.
// Revision : 1.0  initial release
// ============================================================================
module systolic_array_is_ctrl #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int MAX_VECTORS  = 256,
    parameter int ADDR_WIDTH   = 10,
    parameter int PIPE_LATENCY = 7,
    parameter int CNT_WIDTH    = $clog2(MAX_VECTORS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    systolic_array_is_ctrl_if.slave  ctrl
);

    localparam int LOAD_W = $clog2(ARRAY_HEIGHT + 1);
    // Every pipeline stage except the output one: a set bit here means a
    // psum_valid is still to come.
    localparam logic [PIPE_LATENCY-1:0] PV_MASK =
        ~(PIPE_LATENCY'(1) << (PIPE_LATENCY - 1));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                  state_q,    state_d;
    logic [LOAD_W-1:0]       load_cnt_q, load_cnt_d;
    logic [CNT_WIDTH-1:0]    vec_cnt_q,  vec_cnt_d;
    logic [CNT_WIDTH-1:0]    nv_q,       nv_d;
    logic [ADDR_WIDTH-1:0]   in_base_q,  in_base_d;
    logic [ADDR_WIDTH-1:0]   w_base_q,   w_base_d;
    logic                    input_en_q;
    logic                    process_en_q;
    logic [PIPE_LATENCY-1:0] pv_q,       pv_d;
    logic [CNT_WIDTH-1:0]    idx_q,      idx_d;
    logic                    idx_first_q, idx_first_d;

    logic                    job_start;
    logic                    in_rd_en;
    logic                    w_rd_en;
    logic                    busy;
    logic                    done;
    logic                    reuse_sel;
    logic                    pipe_pending;
    logic [CNT_WIDTH-1:0]    nv_clamped;

`ifdef SA_CTRL_INPUT_REUSE_EN
    assign reuse_sel = ctrl.reuse_inputs;
`else
    assign reuse_sel = 1'b0;
`endif

    assign nv_clamped = (ctrl.num_vectors > CNT_WIDTH'(MAX_VECTORS))
                      ? CNT_WIDTH'(MAX_VECTORS) : ctrl.num_vectors;

    // A weight vector is still travelling through the array if it is in the
    // process_en stage or any psum stage short of the output.
    assign pipe_pending = process_en_q | (|(pv_q & PV_MASK));

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        nv_d       = nv_q;
        in_base_d  = in_base_q;
        w_base_d   = w_base_q;
        job_start  = 1'b0;
        in_rd_en   = 1'b0;
        w_rd_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    job_start  = 1'b1;
                    nv_d       = nv_clamped;
                    in_base_d  = ctrl.in_base;
                    w_base_d   = ctrl.w_base;
                    load_cnt_d = '0;
                    vec_cnt_d  = '0;
                    if (reuse_sel) begin
                        state_d = (nv_clamped == '0) ? S_DONE : S_STREAM;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_rd_en = 1'b1;
                if (load_cnt_q == LOAD_W'(ARRAY_HEIGHT - 1)) begin
                    load_cnt_d = '0;
                    state_d    = (nv_q == '0) ? S_DRAIN : S_STREAM;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
                if (vec_cnt_q == nv_q - CNT_WIDTH'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave once the last psum_valid is on the output (or, for
                // an empty job, once the final input_en is out).
                if (!pipe_pending) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // psum_valid pipeline and index tracking
    // ------------------------------------------------------------------
    always_comb begin
        pv_d        = (pv_q << 1) | PIPE_LATENCY'(process_en_q);
        idx_d       = idx_q;
        idx_first_d = idx_first_q;
        if (job_start) begin
            idx_d       = '0;
            idx_first_d = 1'b1;
        end else if (pv_d[PIPE_LATENCY-1]) begin
            // Index is registered alongside psum_valid so it lines up with
            // the vector and then holds until the next one.
            idx_d       = idx_first_q ? '0 : idx_q + 1'b1;
            idx_first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            vec_cnt_q    <= '0;
            nv_q         <= '0;
            in_base_q    <= '0;
            w_base_q     <= '0;
            input_en_q   <= 1'b0;
            process_en_q <= 1'b0;
            pv_q         <= '0;
            idx_q        <= '0;
            idx_first_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            vec_cnt_q    <= vec_cnt_d;
            nv_q         <= nv_d;
            in_base_q    <= in_base_d;
            w_base_q     <= w_base_d;
            input_en_q   <= in_rd_en;
            process_en_q <= w_rd_en;
            pv_q         <= pv_d;
            idx_q        <= idx_d;
            idx_first_q  <= idx_first_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (addresses forced to zero while their enable is low)
    // ------------------------------------------------------------------
    assign ctrl.busy       = busy;
    assign ctrl.done       = done;
    assign ctrl.in_rd_en   = in_rd_en;
    assign ctrl.in_rd_addr = in_rd_en ? in_base_q + ADDR_WIDTH'(load_cnt_q) : '0;
    assign ctrl.w_rd_en    = w_rd_en;
    assign ctrl.w_rd_addr  = w_rd_en ? w_base_q + ADDR_WIDTH'(vec_cnt_q) : '0;
    assign ctrl.input_en   = input_en_q;
    assign ctrl.process_en = process_en_q;
    assign ctrl.psum_valid = pv_q[PIPE_LATENCY-1];
    assign ctrl.psum_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_is_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_is_ctrl
// Purpose  : Self-checking bench for systolic_array_is_ctrl. Each job's
//            expected per-cycle outputs are derived arithmetically from the
//            job parameters (load window, stream window, psum window, done
//            cycle) and compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_array_is_ctrl;

    localparam int H    = 4;
    localparam int MAXV = 256;
    localparam int AW   = 10;
    localparam int L    = 7;
    localparam int CW   = $clog2(MAXV + 1);
    localparam int AMSK = (1 << AW) - 1;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    systolic_array_is_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    systolic_array_is_ctrl #(
        .ARRAY_HEIGHT (H),
        .MAX_VECTORS  (MAXV),
        .ADDR_WIDTH   (AW),
        .PIPE_LATENCY (L),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_idx);
        check_val({tag, " busy"},       bus.busy,       0);
        check_val({tag, " done"},       bus.done,       0);
        check_val({tag, " in_rd_en"},   bus.in_rd_en,   0);
        check_val({tag, " w_rd_en"},    bus.w_rd_en,    0);
        check_val({tag, " input_en"},   bus.input_en,   0);
        check_val({tag, " process_en"}, bus.process_en, 0);
        check_val({tag, " psum_valid"}, bus.psum_valid, 0);
        check_val({tag, " psum_idx"},   bus.psum_idx,   exp_idx);
    endtask

    // Called mid-cycle (negedge); start is sampled at the next posedge (E0).
    // abort_at > 0 pulls rst_n low after checking that cycle.
    task automatic run_job(input string name, input int nv, input int ib, input int wb,
                           input bit r, input bit hold, input int abort_at);
        int    n, s, d, fv, last, e_idx;
        bit    aborted;
        string t;
`ifndef SA_CTRL_INPUT_REUSE_EN
        r = 1'b0;
`endif
        n  = (nv > MAXV) ? MAXV : nv;
        s  = r ? 1 : H + 1;
        fv = s + 1 + L;
        if (n > 0)  d = s + n + L + 1;
        else if (r) d = 1;
        else        d = H + 2;
        last    = (abort_at > 0) ? abort_at + 6 : d + 2;
        aborted = 1'b0;

        bus.start       = 1'b1;
        bus.num_vectors = CW'(nv);
        bus.in_base     = AW'(ib);
        bus.w_base      = AW'(wb);
`ifdef SA_CTRL_INPUT_REUSE_EN
        bus.reuse_inputs = r;
`endif
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            t = $sformatf("%s c%0d", name, c);
            if (aborted) begin
                check_idle(t, 0);
            end else begin
                if (n > 0 && c >= fv) e_idx = (c - fv > n - 1) ? n - 1 : c - fv;
                else                  e_idx = 0;
                check_val({t, " busy"},       bus.busy,       int'(c < d));
                check_val({t, " done"},       bus.done,       int'(c == d));
                check_val({t, " in_rd_en"},   bus.in_rd_en,   int'(!r && c <= H));
                check_val({t, " input_en"},   bus.input_en,   int'(!r && c >= 2 && c <= H + 1));
                check_val({t, " w_rd_en"},    bus.w_rd_en,    int'(c >= s && c < s + n));
                check_val({t, " process_en"}, bus.process_en, int'(c > s && c <= s + n));
                check_val({t, " psum_valid"}, bus.psum_valid, int'(c >= fv && c < fv + n));
                check_val({t, " psum_idx"},   bus.psum_idx,   e_idx);
                if (!r && c <= H)
                    check_val({t, " in_rd_addr"}, bus.in_rd_addr, (ib + c - 1) & AMSK);
                if (c >= s && c < s + n)
                    check_val({t, " w_rd_addr"}, bus.w_rd_addr, (wb + c - s) & AMSK);
            end
            if (c == 1 && !hold) bus.start = 1'b0;
            if (hold && c == d + 1) bus.start = 1'b0;
            if (c == 2) begin
                // Latched job parameters must ignore later input changes.
                bus.num_vectors = CW'($urandom_range(0, (1 << CW) - 1));
                bus.in_base     = AW'($urandom_range(0, AMSK));
                bus.w_base      = AW'($urandom_range(0, AMSK));
            end
            if (abort_at > 0 && c == abort_at) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end
            if (abort_at > 0 && c == abort_at + 1) rst_n = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        bus.in_base     = '0;
        bus.w_base      = '0;
`ifdef SA_CTRL_INPUT_REUSE_EN
        bus.reuse_inputs = 1'b0;
`endif
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check_idle("reset", 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 0);

        run_job("basic",   4,        'h10, 'h20,       1'b0, 1'b0, 0);
        run_job("zero",    0,        'h33, 'h44,       1'b0, 1'b0, 0);
        run_job("hold",    3,        'h05, 'h3F0,      1'b0, 1'b1, 0);
        run_job("abort",   4,        'h10, 'h20,       1'b0, 1'b0, 7);
        run_job("after",   4,        'h10, 'h20,       1'b0, 1'b0, 0);
        run_job("wrap",    4,        'h3FD, AMSK - 1,  1'b0, 1'b0, 0);
        run_job("clamp",   MAXV + 5, 'h100, 'h200,     1'b0, 1'b0, 0);
        run_job("reuse2",  2,        'h11, 'h22,       1'b1, 1'b0, 0);
        run_job("reuse0",  0,        'h11, 'h22,       1'b1, 1'b0, 0);

        for (int k = 0; k < 12; k++) begin
            run_job($sformatf("rnd%0d", k),
                    ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10)),
                    int'($urandom_range(0, AMSK)), int'($urandom_range(0, AMSK)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
